// File: rtl/bcd_nibble_rx_pkg.sv
// bcd_pkg: shared state encoding, BCD limit and frame length for bcd_nibble_rx.
// Frame length is 5 (nibble + odd parity) when BCD_RX_PARITY_EN is defined, else 4.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
`ifdef BCD_RX_PARITY_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif
endpackage

// File: rtl/bcd_nibble_rx_if.sv
// bcd_nibble_rx_if: serial-in bit handshake plus presented-digit handshake.
interface bcd_nibble_rx_if;
  logic       sin;
  logic       sin_valid;
  logic       sin_ready;
  logic [3:0] digit;
  logic       digit_valid;
  logic       out_ready;
  logic       digit_ok;
  logic       par_err;
  modport master (output sin, sin_valid, out_ready,
                  input  sin_ready, digit, digit_valid, digit_ok, par_err);
  modport slave  (input  sin, sin_valid, out_ready,
                  output sin_ready, digit, digit_valid, digit_ok, par_err);
endinterface

// File: rtl/bcd_digit_check.sv
// bcd_digit_check: flags a 4-bit code as legal BCD (0..9).
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [3:0] code,
  output logic       ok
);
  assign ok = code <= BCD_MAX;
endmodule

// File: rtl/bcd_nibble_rx.sv
// bcd_nibble_rx: assembles MSB-first serial bits into a BCD digit and counts rejected digits.
// Optional odd-parity 5th bit enabled by defining BCD_RX_PARITY_EN.
module bcd_nibble_rx
  import bcd_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  bcd_nibble_rx_if.slave   bus,
  output logic [ERR_W-1:0] err_cnt
);
  state_t     state, nxt;
  logic [2:0] bit_cnt;
  logic [N-2:0] sh;
  logic [N-1:0] full;
  logic [3:0] digit_r;
  logic       code_ok, accept, xfer, last, bad;
`ifdef BCD_RX_PARITY_EN
  logic       par_r;
`endif
  assign full            = {sh, bus.sin};
  assign bus.sin_ready   = (state != HOLD) && !clr;
  assign accept          = bus.sin_valid && bus.sin_ready;
  assign xfer            = (state == HOLD) && bus.out_ready;
  assign last            = accept && (bit_cnt == 3'(N - 1));
  assign bus.digit       = digit_r;
  assign bus.digit_valid = state == HOLD;
  assign bus.digit_ok    = (state == HOLD) && code_ok;
`ifdef BCD_RX_PARITY_EN
  assign bus.par_err     = (state == HOLD) && par_r;
`else
  assign bus.par_err     = 1'b0;
`endif
  assign bad             = !code_ok || bus.par_err;
  bcd_digit_check u_chk (.code(digit_r), .ok(code_ok));
  always_comb begin
    nxt = clr ? IDLE
        : (state == HOLD) ? (xfer ? IDLE : HOLD)
        : last ? HOLD
        : accept ? SHIFT
        : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sh      <= '0;
      digit_r <= '0;
      err_cnt <= '0;
`ifdef BCD_RX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else if (clr) begin
      bit_cnt <= '0;
      sh      <= '0;
      err_cnt <= '0;
    end else begin
      if (last) begin
        bit_cnt <= '0;
        sh      <= '0;
        digit_r <= full[N-1 -: 4];
`ifdef BCD_RX_PARITY_EN
        // even population over nibble + parity bit violates odd parity
        par_r   <= ~^full;
`endif
      end else if (accept) begin
        bit_cnt <= bit_cnt + 3'd1;
        sh      <= full[N-2:0];
      end
      if (xfer && bad && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bcd_nibble_rx.sv
// tb_bcd_nibble_rx: vector table, directed corner sequences and a randomized run
// against a queue-based reference model of bcd_nibble_rx.
module tb_bcd_nibble_rx;
  import bcd_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] err_cnt;
  int total = 0;
  int bad = 0;
  int exp_err = 0;
  bcd_nibble_rx_if bus();
  bcd_nibble_rx #(.ERR_W(8)) dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus.slave), .err_cnt(err_cnt));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       ok;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] frame(input logic [3:0] d);
    return {d, ~^d};
  endfunction

  task automatic send(input logic [4:0] f);
    for (int i = 0; i < N; i++) begin
      bus.sin_valid = 1'b1;
      bus.sin = f[4-i];
      tick();
    end
    bus.sin_valid = 1'b0;
  endtask

  task automatic count_reject();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endtask

  task automatic xfer_chk(input string nm, input logic [3:0] d, input logic ok, input logic par);
    chk({nm, "_valid"}, 32'(bus.digit_valid), 32'd1);
    chk({nm, "_digit"}, 32'(bus.digit), 32'(d));
    chk({nm, "_ok"}, 32'(bus.digit_ok), 32'(ok));
    chk({nm, "_par"}, 32'(bus.par_err), 32'(par));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (!ok || par) count_reject();
    chk({nm, "_gone"}, 32'(bus.digit_valid), 32'd0);
    chk({nm, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    int q[$];
    bit hold;
    logic [3:0] md;
    logic mp;
    logic sv, sb, ordy;
    vecs[0] = '{4'h0, 1'b1};
    vecs[1] = '{4'h9, 1'b1};
    vecs[2] = '{4'hA, 1'b0};
    vecs[3] = '{4'hF, 1'b0};
    vecs[4] = '{4'h5, 1'b1};
    vecs[5] = '{4'hC, 1'b0};
    vecs[6] = '{4'h1, 1'b1};
    vecs[7] = '{4'h8, 1'b1};
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.digit_valid), 32'd0);
    chk("rst_digit", 32'(bus.digit), 32'd0);
    chk("rst_ok", 32'(bus.digit_ok), 32'd0);
    chk("rst_par", 32'(bus.par_err), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.sin_ready), 32'd1);
    tick();
    // 1,0,0,1 with downstream ready throughout: one-cycle presentation
    bus.out_ready = 1'b1;
    send(frame(4'h9));
    chk("n9_valid", 32'(bus.digit_valid), 32'd1);
    chk("n9_digit", 32'(bus.digit), 32'h9);
    chk("n9_ok", 32'(bus.digit_ok), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    chk("n9_gone", 32'(bus.digit_valid), 32'd0);
    chk("n9_err", 32'(err_cnt), 32'd0);
    send(frame(4'hA));
    xfer_chk("nA", 4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(frame(vecs[i].d));
      xfer_chk($sformatf("vec%0d", i), vecs[i].d, vecs[i].ok, 1'b0);
    end
    // async reset mid-nibble discards the partial digit and the error count
    bus.sin_valid = 1'b1;
    bus.sin = 1'b1;
    tick();
    tick();
    bus.sin_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.digit_valid), 32'd0);
    chk("mid_rst_digit", 32'(bus.digit), 32'd0);
    chk("mid_rst_ok", 32'(bus.digit_ok), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    exp_err = 0;
    #1;
    chk("mid_rst_ready", 32'(bus.sin_ready), 32'd1);
    tick();
    send(frame(4'h3));
    xfer_chk("after_rst", 4'h3, 1'b1, 1'b0);
    // backpressure: bits offered during HOLD must not be absorbed
    send(frame(4'h6));
    bus.sin_valid = 1'b1;
    bus.sin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(bus.sin_ready), 32'd0);
      chk("bp_valid", 32'(bus.digit_valid), 32'd1);
      chk("bp_digit", 32'(bus.digit), 32'h6);
      tick();
    end
    bus.out_ready = 1'b1;
    chk("bp_xfer_ready", 32'(bus.sin_ready), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    bus.sin_valid = 1'b0;
    chk("bp_gone", 32'(bus.digit_valid), 32'd0);
    chk("bp_err", 32'(err_cnt), 32'(exp_err));
    send(frame(4'h5));
    xfer_chk("bp_next", 4'h5, 1'b1, 1'b0);
    // saturation at 255
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(frame(4'hF));
      tick();
      count_reject();
    end
    bus.out_ready = 1'b0;
    chk("sat_err", 32'(err_cnt), 32'd255);
    send(frame(4'hF));
    bus.out_ready = 1'b1;
    clr = 1'b1;
    #1;
    chk("clr_ready", 32'(bus.sin_ready), 32'd0);
    tick();
    clr = 1'b0;
    bus.out_ready = 1'b0;
    exp_err = 0;
    chk("clr_err", 32'(err_cnt), 32'd0);
    chk("clr_valid", 32'(bus.digit_valid), 32'd0);
    // clr aborts a partial nibble
    bus.sin_valid = 1'b1;
    bus.sin = 1'b1;
    tick();
    tick();
    bus.sin_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    send(frame(4'h2));
    xfer_chk("clr_abort", 4'h2, 1'b1, 1'b0);
`ifdef BCD_RX_PARITY_EN
    send({4'b0111, 1'b1});
    xfer_chk("par_bad", 4'h7, 1'b1, 1'b1);
    send({4'b0111, 1'b0});
    xfer_chk("par_good", 4'h7, 1'b1, 1'b0);
`endif
    // randomized traffic against the reference model
    hold = 1'b0;
    md = '0;
    mp = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      sv = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      ordy = $urandom_range(0, 3) != 0;
      bus.sin_valid = sv;
      bus.sin = sb;
      bus.out_ready = ordy;
      #1;
      chk("rnd_ready", 32'(bus.sin_ready), 32'(!hold));
      chk("rnd_valid", 32'(bus.digit_valid), 32'(hold));
      if (hold) begin
        chk("rnd_digit", 32'(bus.digit), 32'(md));
        chk("rnd_ok", 32'(bus.digit_ok), 32'(md <= 4'd9));
        chk("rnd_par", 32'(bus.par_err), 32'(mp));
      end else begin
        chk("rnd_ok_idle", 32'(bus.digit_ok), 32'd0);
      end
      chk("rnd_err", 32'(err_cnt), 32'(exp_err));
      if (hold) begin
        if (ordy) begin
          hold = 1'b0;
          if (md > 4'd9 || mp) count_reject();
        end
      end else if (sv) begin
        q.push_back(int'(sb));
        if (q.size() == N) begin
          md = 4'(q[0] * 8 + q[1] * 4 + q[2] * 2 + q[3]);
          mp = (N == 5) && (q.sum() % 2 == 0);
          hold = 1'b1;
          q.delete();
        end
      end
      tick();
    end
    bus.sin_valid = 1'b0;
    bus.out_ready = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_nibble_rx.md
BCD_NIBBLE_RX -- requirements
Module: bcd_nibble_rx

Interface
REQ-001 Parameter: ERR_W, default 8, width of the invalid-digit error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 clr  input  1  synchronous clear: aborts a partial nibble and zeroes err_cnt.
REQ-005 sin  input  1  serial data bit, MSB first.
REQ-006 sin_valid  input  1  sin carries a bit this cycle.
REQ-007 sin_ready  output  1  block accepts a bit this cycle.
REQ-008 digit  output  4  assembled nibble.
REQ-009 digit_valid  output  1  digit is presented downstream.
REQ-010 out_ready  input  1  downstream accepts digit.
REQ-011 digit_ok  output  1  1 iff digit_valid and digit <= 9 (legal BCD).
REQ-012 par_err  output  1  parity failure flag for the presented digit.
REQ-013 err_cnt  output  ERR_W  saturating count of rejected digits.

Function
REQ-014 The FSM SHALL have states IDLE (no bits held), SHIFT (1 to N-1 bits held) and HOLD (digit presented); N=4, or 5 with parity.
REQ-015 A bit SHALL be accepted when sin_valid && sin_ready; sin_ready = (state != HOLD) && !clr.
REQ-016 An accepted bit SHALL be shifted into the LSB of the shift register, and bit_cnt SHALL increment.
REQ-017 IDLE->SHIFT on the first accepted bit; SHIFT->HOLD on the Nth accepted bit; HOLD->IDLE on transfer (digit_valid && out_ready).
REQ-018 digit_valid SHALL rise on the cycle after the Nth bit is accepted (latency 1), then stay high with digit stable until transfer.
REQ-019 sin_valid low mid-nibble SHALL hold bit_cnt and the shift register indefinitely; there is no timeout.
REQ-020 In HOLD, sin SHALL be ignored; no bit is accepted in the transfer cycle; the next nibble may start the following cycle.
REQ-021 digit_ok and par_err SHALL be 0 whenever digit_valid=0.
REQ-022 On each transfer where digit_ok=0 or par_err=1, err_cnt SHALL increment by 1, saturating at 2^ERR_W-1 (no wrap).
REQ-023 clr SHALL force IDLE, bit_cnt=0, digit_valid=0 and err_cnt=0, and SHALL win over a simultaneous bit accept, transfer or increment.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, bit_cnt=0, shift register=0, digit=0, digit_valid=0, err_cnt=0.
REQ-025 On rst_n low, asynchronously: derived outputs SHALL read digit_ok=0 and par_err=0, with sin_ready=1 once rst_n is released.
REQ-026 Reset mid-nibble or in HOLD SHALL discard the partial or presented digit without counting it.

Configuration
REQ-027 With BCD_RX_PARITY_EN defined, N=5: the 5th bit SHALL be an odd-parity bit over the nibble, not stored in digit.
REQ-028 With BCD_RX_PARITY_EN defined, par_err=1 SHALL be presented with digit_valid when the count of ones across the nibble and the parity bit is even.
REQ-029 Without BCD_RX_PARITY_EN, N=4 and par_err SHALL be tied to 0.

Structure
REQ-030 The shared package bcd_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2) and BCD_MAX=4'd9.
REQ-031 The combinational validity decode (digit <= 9) SHALL be a sub-module, bcd_digit_check (in: 4-bit code, out: 1-bit ok).

Verification
REQ-032 Reset: assert rst_n=0 mid-SHIFT -> all outputs 0 immediately; after release, sin_ready=1 and err_cnt=0.
REQ-033 Shift 1,0,0,1 back-to-back with out_ready=1 -> digit=4'h9, digit_ok=1, digit_valid high 1 cycle after the 4th bit; err_cnt unchanged.
REQ-034 Shift 1,0,1,0 -> digit=4'hA, digit_ok=0; err_cnt goes 0->1 on the transfer cycle.
REQ-035 Backpressure: out_ready=0 for 5 cycles while sin_valid=1 -> digit held, sin_ready=0, no bits absorbed; transfer on the 6th cycle, then the next nibble assembles correctly.
REQ-036 Saturation: 300 digits of 4'hF -> err_cnt stops at 255; clr in the same cycle as a further invalid transfer -> err_cnt=0.
REQ-037 BCD_RX_PARITY_EN build: 0,1,1,1 with parity 1 -> par_err=1, err_cnt+1; 0,1,1,1 with parity 0 -> par_err=0, digit_ok=1.
